lcd_nibble_rx: RTL

LCD_NIBBLE_RX -- requirements
Module: lcd_nibble_rx

---
 rtl/lcd_nibble_rx_if.sv | 21 ++
 rtl/lcd_nibble_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_rx_if.sv
// Bundle of the HD44780-style 4-bit write bus and the receiver's byte/status outputs.
// master = transmitter/observer side, slave = lcd_nibble_rx.
interface lcd_nibble_rx_if;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output lcd_e, lcd_db,
        input  data, valid, err, err_code, busy
    );

    modport slave (
        input  lcd_e, lcd_db,
        output data, valid, err, err_code, busy
    );
endinterface

// File: rtl/lcd_nibble_rx.sv
// Receives a byte as two nibbles on lcd_db[7:4], strobed by lcd_e, and checks setup,
// pulse width, inter-nibble gap and timeout. Emits {MSN, LSN} with a valid pulse or an err pulse.
module lcd_nibble_rx #(
    parameter int unsigned SETUP_MIN = 2,
    parameter int unsigned PULSE_MIN = 12,
    parameter int unsigned GAP_MIN   = 50,
    parameter int unsigned TIMEOUT   = 4095
) (
    input logic           clk,
    input logic           reset,
    lcd_nibble_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MSN_HIGH = 3'd1,
        WAIT_LSN = 3'd2,
        LSN_HIGH = 3'd3,
        DONE     = 3'd4,
        RECOVER  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        e_q;
    logic [3:0]  nib_prev_q;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  nib_lat_q, nib_lat_d;
    logic [3:0]  msn_q, msn_d;
    logic [15:0] high_q, high_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;

    logic [3:0]  nib;
    logic        rise;
    logic        fall;
    logic [15:0] high_inc;
    logic [15:0] gap_inc;
    logic        setup_ok;
    logic        unused_low;

    assign nib        = bus.lcd_db[7:4];
    assign unused_low = ^bus.lcd_db[3:0];
    assign rise       = bus.lcd_e & ~e_q;
    assign fall       = ~bus.lcd_e & e_q;
    assign high_inc   = (high_q == 16'hFFFF) ? high_q : high_q + 16'd1;
    assign gap_inc    = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
    assign setup_ok   = 32'(stable_q) >= SETUP_MIN;

    // Counts how long the nibble has been held with lcd_e low; any strobe or change restarts at 1.
    always_comb begin
        stable_d = stable_q;
        if (bus.lcd_e || (nib != nib_prev_q)) begin
            stable_d = 4'd1;
        end else if (stable_q != 4'hF) begin
            stable_d = stable_q + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        nib_lat_d = nib_lat_q;
        msn_d     = msn_q;
        high_d    = high_q;
        gap_d     = gap_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (setup_ok) begin
                        state_d   = MSN_HIGH;
                        nib_lat_d = nib;
                        high_d    = 16'd1;
                    end else begin
                        state_d = RECOVER;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end
                end
            end

            MSN_HIGH, LSN_HIGH: begin
                if (bus.lcd_e) begin
                    if (nib != nib_lat_q) begin
                        state_d = RECOVER;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        high_d = high_inc;
                    end
                end else if (fall) begin
                    if (32'(high_q) >= PULSE_MIN) begin
                        if (state_q == MSN_HIGH) begin
                            msn_d   = nib_lat_q;
                            gap_d   = 16'd1;
                            state_d = WAIT_LSN;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end
                end
            end

            WAIT_LSN: begin
                // Expiry wins over a simultaneous rise, which is then ignored.
                if (32'(gap_q) + 32'd1 >= TIMEOUT) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end else if (rise) begin
                    if (32'(gap_q) < GAP_MIN) begin
                        state_d = RECOVER;
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                    end else if (!setup_ok) begin
                        state_d = RECOVER;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        state_d   = LSN_HIGH;
                        nib_lat_d = nib;
                        high_d    = 16'd1;
                    end
                end else begin
                    gap_d = gap_inc;
                end
            end

            DONE: begin
                data_d  = {msn_q, nib_lat_q};
                valid_d = 1'b1;
                state_d = IDLE;
            end

            RECOVER: begin
                if (!bus.lcd_e) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            e_q        <= 1'b0;
            nib_prev_q <= 4'd0;
            stable_q   <= 4'd0;
            nib_lat_q  <= 4'd0;
            msn_q      <= 4'd0;
            high_q     <= 16'd0;
            gap_q      <= 16'd0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            e_q        <= bus.lcd_e;
            nib_prev_q <= nib;
            stable_q   <= stable_d;
            nib_lat_q  <= nib_lat_d;
            msn_q      <= msn_d;
            high_q     <= high_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
